// File: rtl/l2_cache_control.sv
// Control FSM for the 4-way, 8-set write-back L2: hit/miss decision, per-set
// pseudo-LRU state, victim choice, writeback and line-fill sequencing.
module l2_cache_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       l2_read,
  input  logic       l2_write,
  input  logic [2:0] set,
  input  logic [3:0] hit,
  input  logic [3:0] valid,
  input  logic [3:0] dirty,
  input  logic       pmem_resp,
  output logic       l2_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       pmem_addr_sel,
  output logic [1:0] tagmux_sel,
  output logic [3:0] way_load,
  output logic       data_src_sel,
  output logic       dirty_in
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

  state_t     state_q, state_d;
  logic [1:0] victim_q, victim_d;
  logic [2:0] plru_q [8];
  logic       plru_upd;
  logic [1:0] hit_way;
  logic [1:0] miss_way;

  function automatic logic [1:0] first_one(input logic [3:0] v);
    if (v[0])      first_one = 2'd0;
    else if (v[1]) first_one = 2'd1;
    else if (v[2]) first_one = 2'd2;
    else           first_one = 2'd3;
  endfunction

  // Tree PLRU: b0 picks the half, b1/b2 pick the way within each half.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    plru_victim = b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    plru_touch    = b;
    plru_touch[0] = ~w[1];
    if (!w[1]) plru_touch[1] = ~w[0];
    else       plru_touch[2] = ~w[0];
  endfunction

  assign hit_way  = first_one(hit);
  assign miss_way = (&valid) ? plru_victim(plru_q[set]) : first_one(~valid);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    plru_upd      = 1'b0;
    l2_resp       = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    tagmux_sel    = 2'b00;
    way_load      = 4'b0000;
    data_src_sel  = 1'b0;
    dirty_in      = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (l2_read || l2_write) state_d = CHECK;
        end
        CHECK: begin
          if (!(l2_read || l2_write)) begin
            state_d = IDLE;
          end else if (|hit) begin
            l2_resp  = 1'b1;
            plru_upd = 1'b1;
            if (l2_write) begin
              way_load = 4'b0001 << hit_way;
              dirty_in = 1'b1;
            end
            state_d = IDLE;
          end else begin
            victim_d = miss_way;
            state_d  = (valid[miss_way] && dirty[miss_way]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          tagmux_sel    = victim_q;
          if (pmem_resp) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            way_load     = 4'b0001 << victim_q;
            data_src_sel = 1'b1;
            state_d      = CHECK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      victim_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Only the set being accessed has its PLRU bits rewritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) plru_q[i] <= 3'b000;
    end else if (plru_upd) begin
      plru_q[set] <= plru_touch(plru_q[set], hit_way);
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed table-driven bench for l2_cache_control, plus hand-written
// sequences for request drop and asynchronous reset during writeback.
module tb_l2_cache_control;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       l2_read, l2_write;
  logic [2:0] set;
  logic [3:0] hit, valid, dirty;
  logic       pmem_resp;
  logic       l2_resp, pmem_read, pmem_write, pmem_addr_sel;
  logic [1:0] tagmux_sel;
  logic [3:0] way_load;
  logic       data_src_sel, dirty_in;

  int nvec = 0;
  int nerr = 0;

  l2_cache_control dut (
    .clk(clk), .reset_n(reset_n), .l2_read(l2_read), .l2_write(l2_write),
    .set(set), .hit(hit), .valid(valid), .dirty(dirty), .pmem_resp(pmem_resp),
    .l2_resp(l2_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .tagmux_sel(tagmux_sel), .way_load(way_load),
    .data_src_sel(data_src_sel), .dirty_in(dirty_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  s;
    logic [3:0]  h;
    logic [3:0]  va;
    logic [3:0]  d;
    logic        pr;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  localparam logic [11:0] Z = 12'h000;
  localparam logic [3:0]  F = 4'b1111;

  // {l2_resp, pmem_read, pmem_write, pmem_addr_sel, tagmux_sel, way_load, data_src_sel, dirty_in}
  function automatic logic [11:0] o(input logic resp, prd, pwr, asel, input logic [1:0] ts,
                                    input logic [3:0] wl, input logic ds, di);
    o = {resp, prd, pwr, asel, ts, wl, ds, di};
  endfunction

  function automatic logic [11:0] actual();
    actual = {l2_resp, pmem_read, pmem_write, pmem_addr_sel, tagmux_sel, way_load, data_src_sel, dirty_in};
  endfunction

  task automatic add(input logic rd, wr, input logic [2:0] s, input logic [3:0] h, va, d,
                     input logic pr, input logic [11:0] exp);
    vec_t v;
    v = '{rd: rd, wr: wr, s: s, h: h, va: va, d: d, pr: pr, exp: exp};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] a;
    a = actual();
    nvec++;
    if (a !== exp) begin
      nerr++;
      $display("FAIL %s: outputs got %03h want %03h", name, a, exp);
    end
  endtask

  task automatic drive(input logic rd, wr, input logic [2:0] s, input logic [3:0] h, va, d,
                       input logic pr);
    @(negedge clk);
    l2_read = rd; l2_write = wr; set = s; hit = h; valid = va; dirty = d; pmem_resp = pr;
    #1;
  endtask

  task automatic check_plru(input string name, input int s, input logic [2:0] exp);
    nvec++;
    if (dut.plru_q[s] !== exp) begin
      nerr++;
      $display("FAIL %s: plru[%0d] got %03b want %03b", name, s, dut.plru_q[s], exp);
    end
  endtask

  task automatic read_hit(input logic [2:0] s, input logic [3:0] h);
    add(1, 0, s, h, F, 4'b0000, 0, Z);
    add(1, 0, s, h, F, 4'b0000, 0, o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    add(0, 0, s, 4'b0000, F, 4'b0000, 0, Z);
  endtask

  initial begin
    logic [11:0] rdx, wbx;
    rdx = o(0, 1, 0, 0, 2'b00, 4'b0000, 0, 0);

    reset_n = 1'b0; l2_read = 0; l2_write = 0; set = 0; hit = 0; valid = 0; dirty = 0; pmem_resp = 0;
    #1;
    check("reset_outputs", Z);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // set 3, all invalid: fill way 0 after five ALLOCATE cycles
    add(1, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0, Z);
    add(1, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0, Z);
    for (int i = 0; i < 4; i++) add(1, 0, 3, 4'b0000, 4'b0000, 4'b0000, 0, rdx);
    add(1, 0, 3, 4'b0000, 4'b0000, 4'b0000, 1, o(0, 1, 0, 0, 2'b00, 4'b0001, 1, 0));
    add(1, 0, 3, 4'b0001, 4'b0001, 4'b0000, 0, o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    add(0, 0, 3, 4'b0000, 4'b0001, 4'b0000, 1, Z);
    add(0, 0, 3, 4'b0000, 4'b0001, 4'b0000, 0, Z);
    // set 2 write hit on way 2
    add(0, 1, 2, 4'b0100, F, 4'b0000, 0, Z);
    add(0, 1, 2, 4'b0100, F, 4'b0000, 0, o(1, 0, 0, 0, 2'b00, 4'b0100, 0, 1));
    add(0, 0, 2, 4'b0000, F, 4'b0000, 0, Z);
    // set 7 write with two hit bits: lowest way wins; stray pmem_resp ignored
    add(0, 1, 7, 4'b0110, F, 4'b0000, 0, Z);
    add(0, 1, 7, 4'b0110, F, 4'b0000, 1, o(1, 0, 0, 0, 2'b00, 4'b0010, 0, 1));
    add(0, 0, 7, 4'b0000, F, 4'b0000, 0, Z);
    // set 5: touch way 1 (PLRU=001), then dirty miss evicts way 2
    read_hit(5, 4'b0010);
    wbx = o(0, 0, 1, 1, 2'b10, 4'b0000, 0, 0);
    add(1, 0, 5, 4'b0000, F, F, 0, Z);
    add(1, 0, 5, 4'b0000, F, F, 0, Z);
    add(1, 0, 5, 4'b0000, F, F, 0, wbx);
    add(1, 0, 5, 4'b0000, F, F, 0, wbx);
    add(1, 0, 5, 4'b0000, F, F, 1, wbx);
    add(1, 0, 5, 4'b0000, F, F, 0, rdx);
    add(1, 0, 5, 4'b0000, F, F, 1, o(0, 1, 0, 0, 2'b00, 4'b0100, 1, 0));
    add(1, 0, 5, 4'b0100, F, F, 0, o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    add(0, 0, 5, 4'b0000, F, F, 0, Z);
    // set 6: ways 0,1 valid, all dirty bits set; first invalid way 2 is clean
    add(1, 0, 6, 4'b0000, 4'b0011, F, 0, Z);
    add(1, 0, 6, 4'b0000, 4'b0011, F, 0, Z);
    add(1, 0, 6, 4'b0000, 4'b0011, F, 1, o(0, 1, 0, 0, 2'b00, 4'b0100, 1, 0));
    add(1, 0, 6, 4'b0100, 4'b0111, F, 0, o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    add(0, 0, 6, 4'b0000, 4'b0111, F, 0, Z);
    // set 0: access ways 0..3, then clean full miss picks way 0
    for (int w = 0; w < 4; w++) read_hit(0, 4'(1 << w));
    add(1, 0, 0, 4'b0000, F, 4'b0000, 0, Z);
    add(1, 0, 0, 4'b0000, F, 4'b0000, 0, Z);
    add(1, 0, 0, 4'b0000, F, 4'b0000, 0, rdx);
    add(1, 0, 0, 4'b0000, F, 4'b0000, 1, o(0, 1, 0, 0, 2'b00, 4'b0001, 1, 0));
    add(1, 0, 0, 4'b0001, F, 4'b0000, 0, o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    add(0, 0, 0, 4'b0000, F, 4'b0000, 0, Z);

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].s, tbl[i].h, tbl[i].va, tbl[i].d, tbl[i].pr);
      check($sformatf("row%0d", i), tbl[i].exp);
    end
    check_plru("plru_set3", 3, 3'b011);
    check_plru("plru_set2", 2, 3'b100);
    check_plru("plru_set5", 5, 3'b100);
    check_plru("plru_set0", 0, 3'b011);

    // request dropped during CHECK of a miss
    drive(1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("drop_idle", Z);
    drive(0, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("drop_check", Z);
    drive(0, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("drop_after1", Z);
    drive(0, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("drop_after2", Z);
    drive(1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("rereq_idle", Z);
    drive(1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 0); check("rereq_check", Z);
    drive(1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 1); check("rereq_fill", o(0, 1, 0, 0, 2'b00, 4'b0001, 1, 0));
    drive(1, 0, 4, 4'b0001, 4'b0001, 4'b0000, 0); check("rereq_resp", o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    drive(0, 0, 4, 4'b0000, 4'b0001, 4'b0000, 0); check("rereq_done", Z);

    // asynchronous reset while in WRITEBACK (set 3 PLRU=011 -> victim way 2)
    drive(1, 0, 3, 4'b0000, F, F, 0); check("wbrst_idle", Z);
    drive(1, 0, 3, 4'b0000, F, F, 0); check("wbrst_check", Z);
    drive(1, 0, 3, 4'b0000, F, F, 0); check("wbrst_wb", o(0, 0, 1, 1, 2'b10, 4'b0000, 0, 0));
    #1 reset_n = 1'b0;
    #1 check("wbrst_async", Z);
    for (int i = 0; i < 8; i++) check_plru("wbrst_plru", i, 3'b000);
    @(negedge clk);
    l2_read = 0; l2_write = 0; pmem_resp = 0;
    reset_n = 1'b1;
    // after reset PLRU[3]=000, so the full dirty miss now evicts way 0
    drive(1, 0, 3, 4'b0000, F, F, 0); check("post_idle", Z);
    drive(1, 0, 3, 4'b0000, F, F, 0); check("post_check", Z);
    drive(1, 0, 3, 4'b0000, F, F, 1); check("post_wb", o(0, 0, 1, 1, 2'b00, 4'b0000, 0, 0));
    drive(1, 0, 3, 4'b0000, F, F, 1); check("post_fill", o(0, 1, 0, 0, 2'b00, 4'b0001, 1, 0));
    drive(1, 0, 3, 4'b0001, F, F, 0); check("post_resp", o(1, 0, 0, 0, 2'b00, 4'b0000, 0, 0));
    drive(0, 0, 3, 4'b0000, F, F, 0); check("post_done", Z);
    check_plru("post_plru3", 3, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/l2_cache_control.md
# l2_cache_control

Control FSM for the 4-way, 8-set, write-back L2 cache in the LC-3b memory hierarchy, between the L1 miss path and physical memory. Per request it decides hit/miss, owns the per-set pseudo-LRU state, and picks the victim way. For a dirty victim it drives the writeback-address tag mux select and pmem handshake, then sequences the line fill and array load strobes.

## Interface
- No parameters. Fixed geometry: 4 ways, 8 sets, 16-byte lines; address = tag[15:7], set[6:4], offset[3:0].
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- l2_read  in  1  L1 line-read request; held until l2_resp.
- l2_write  in  1  L1 line-write request; held until l2_resp; never asserted together with l2_read.
- set  in  lc3b_3bit  set index of the current request; stable while the request is held.
- hit  in  4  per-way tag-match AND valid for the indexed set, from the arrays.
- valid  in  4  per-way valid bits for the indexed set.
- dirty  in  4  per-way dirty bits for the indexed set.
- pmem_resp  in  1  one-cycle completion pulse from physical memory.
- l2_resp  out  1  one-cycle completion pulse to L1.
- pmem_read  out  1  line-fill request to physical memory.
- pmem_write  out  1  line-writeback request to physical memory.
- pmem_addr_sel  out  1  0 = request address, 1 = writeback address from the tag mux.
- tagmux_sel  out  lc3b_2bit  way whose tag forms the writeback address.
- way_load  out  4  one-hot load strobe for data+tag+valid of one way.
- data_src_sel  out  1  array data input: 0 = L1 write data, 1 = pmem line.
- dirty_in  out  1  value written to the dirty bit of the loaded way.

## Operation
- States: IDLE, CHECK, WRITEBACK, ALLOCATE. Reset state is IDLE.
- IDLE: on l2_read or l2_write, go to CHECK. Arrays read synchronously, so hit/valid/dirty are valid in CHECK.
- CHECK, request dropped: return to IDLE, no side effects.
- CHECK, hit: hit way hw = lowest index with hit set.
  - Pulse l2_resp.
  - Update the PLRU of `set` with hw.
  - On write, also assert way_load[hw], data_src_sel=0, dirty_in=1.
  - Go to IDLE.
- CHECK, miss: select victim v and latch it into victim_q.
  - v = lowest-index way with valid=0.
  - If all four ways are valid, v is the PLRU victim.
  - If valid[v] & dirty[v], go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: hold pmem_write=1, pmem_addr_sel=1, tagmux_sel=victim_q until pmem_resp, then go to ALLOCATE.
- ALLOCATE: hold pmem_read=1, pmem_addr_sel=0.
  - On pmem_resp, same cycle: way_load[victim_q]=1, data_src_sel=1, dirty_in=0.
  - Go to CHECK; the retry hits, which performs the PLRU update and any write merge.
- PLRU: 3 bits per set {b2,b1,b0}, 24 flops total, all 0 after reset.
  - Victim: b0=0 gives way {0,b1}; b0=1 gives way {1,b2}.
  - Access to way w: b0 = ~w[1]; if w[1]=0 then b1 = ~w[0], else b2 = ~w[0].
  - Only the accessed set's bits change.
- Default outputs (all non-listed states, and while reset_n=0): every output 0; tagmux_sel=2'b00.

## Timing
- Outputs are combinational from state, victim_q and inputs; no output registers.
- Hit latency: request seen in IDLE, l2_resp in the following cycle (CHECK).
- Clean miss: IDLE, CHECK, ALLOCATE (N cycles to pmem_resp), CHECK with l2_resp.
- Dirty miss: adds WRITEBACK before ALLOCATE.
- pmem_read and pmem_write are never asserted together. Each stays high through its pmem_resp cycle and drops the next cycle.
- Back-to-back requests: after l2_resp the FSM is in IDLE one cycle before accepting the next request.
- Asynchronous reset mid-operation (any state): FSM goes to IDLE, PLRU clears, victim_q clears, all outputs drop immediately. An in-flight pmem transaction is abandoned.
- A pmem_resp arriving in IDLE or CHECK is ignored.

## Test plan
- Reset, then read set 3, all ways invalid:
  - CHECK selects v=0 and goes to ALLOCATE; pmem_read=1, pmem_addr_sel=0.
  - pmem_resp after 5 cycles gives way_load=4'b0001, data_src_sel=1, dirty_in=0.
  - Next cycle CHECK (hit=0001) gives l2_resp, and PLRU[3]=3'b011.
- Set 2 all valid, hit=4'b0100, write:
  - l2_resp in the cycle after the request, with way_load=4'b0100, data_src_sel=0, dirty_in=1.
  - PLRU[2] b0=0 and b2=1, b1 unchanged.
- Set 5 all valid and dirty, PLRU[5]=3'b001, miss:
  - victim way 2 (b0=1, b2=0); WRITEBACK with tagmux_sel=2'b10, pmem_addr_sel=1, pmem_write=1.
  - After pmem_resp, ALLOCATE with pmem_read=1 and way_load=4'b0100 on the fill.
- Set 0: access ways 0,1,2,3 in order, then miss with all valid and clean:
  - victim is way 0; no WRITEBACK state is entered.
- Assert reset_n=0 during WRITEBACK:
  - pmem_write drops asynchronously; after release the state is IDLE and PLRU is all zero.
- In CHECK during a miss, drop l2_read:
  - FSM returns to IDLE; no pmem request, no way_load, and no l2_resp.
